// File: rtl/morse_keyer_tx.sv
// Morse keyer: plays one letter (element count + dot/dash pattern) on the key line with unit timing.
// Optional audio square wave on tone when MORSE_TONE_EN is defined; otherwise tone is tied low.
module morse_keyer_tx #(
  parameter int CLK_PER_UNIT = 50_000_000,
  parameter int TONE_HALF    = 25_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] sym_len,
  input  logic [4:0] sym_pat,
  input  logic       abort,
  output logic       key,
  output logic       busy,
  output logic       done,
  output logic       tone
);

  localparam int PW = $clog2(CLK_PER_UNIT);

  typedef enum logic [2:0] {IDLE, MARK, EGAP, LGAP, WGAP} state_t;

  state_t         state, state_next;
  logic [PW-1:0]  pre;
  logic [2:0]     units;
  logic [2:0]     idx;
  logic [4:0]     pat;
  logic [2:0]     len_clamped;
  logic [2:0]     phase_units;
  logic           unit_end;
  logic           phase_end;
  logic           load;
  logic           done_next;

  if (CLK_PER_UNIT < 2 || TONE_HALF < 1) begin : g_bad_param
    $error("morse_keyer_tx: CLK_PER_UNIT must be >= 2 and TONE_HALF >= 1");
  end

  assign len_clamped = (sym_len > 3'd5) ? 3'd5 : sym_len;
  assign unit_end    = (pre == PW'(CLK_PER_UNIT - 1));
  assign phase_end   = unit_end && (units == phase_units - 3'd1);

  always_comb begin
    phase_units = 3'd1;
    case (state)
      MARK:    phase_units = pat[idx] ? 3'd3 : 3'd1;
      LGAP:    phase_units = 3'd3;
      WGAP:    phase_units = 3'd4;
      default: phase_units = 3'd1;
    endcase
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          load       = 1'b1;
          state_next = (len_clamped == 3'd0) ? WGAP : MARK;
        end
      end
      MARK: if (phase_end) state_next = (idx != 3'd0) ? EGAP : LGAP;
      EGAP: if (phase_end) state_next = MARK;
      LGAP, WGAP: begin
        if (phase_end) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    // Abort only cancels an active letter; in IDLE the accept wins.
    if (abort && state != IDLE) begin
      state_next = IDLE;
      done_next  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= done_next;
    end
  end

  // Prescaler and unit counter restart on every state entry so each phase is whole units.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre   <= '0;
      units <= 3'd0;
    end else if (state_next != state) begin
      pre   <= '0;
      units <= 3'd0;
    end else if (state != IDLE) begin
      if (unit_end) begin
        pre   <= '0;
        units <= units + 3'd1;
      end else begin
        pre   <= pre + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx <= 3'd0;
      pat <= 5'd0;
    end else if (load) begin
      idx <= len_clamped - 3'd1;
      pat <= sym_pat;
    end else if (state == EGAP && phase_end) begin
      idx <= idx - 3'd1;
    end
  end

  assign in_ready = (state == IDLE);
  assign busy     = ~in_ready;
  assign key      = (state == MARK);

`ifdef MORSE_TONE_EN
  localparam int TW = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;

  logic [TW-1:0] tone_cnt;
  logic          tone_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tone_cnt <= '0;
      tone_q   <= 1'b0;
    end else if (!key) begin
      tone_cnt <= '0;
      tone_q   <= 1'b0;
    end else if (tone_cnt == TW'(TONE_HALF - 1)) begin
      tone_cnt <= '0;
      tone_q   <= ~tone_q;
    end else begin
      tone_cnt <= tone_cnt + 1'b1;
    end
  end

  // Gate with key so the wave stops in the same cycle the mark ends.
  assign tone = tone_q & key;
`else
  assign tone = 1'b0;
`endif

endmodule

// File: tb/tb_morse_keyer_tx.sv
// Bench for morse_keyer_tx with CLK_PER_UNIT=4: directed and random letters compared to a unit-timing model.
module tb_morse_keyer_tx;
  localparam int U  = 4;
  localparam int TH = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] sym_len = 3'd0;
  logic [4:0] sym_pat = 5'd0;
  logic       in_ready, key, busy, done, tone;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  morse_keyer_tx #(.CLK_PER_UNIT(U), .TONE_HALF(TH)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .sym_len(sym_len), .sym_pat(sym_pat), .abort(abort),
    .key(key), .busy(busy), .done(done), .tone(tone)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Expected key level per clock, straight from the unit timing rules.
  function automatic void build(input logic [2:0] len, input logic [4:0] pat);
    int l;
    exp_q.delete();
    l = (len > 5) ? 5 : int'(len);
    if (l == 0) begin
      repeat (4 * U) exp_q.push_back(1'b0);
    end else begin
      for (int i = l - 1; i >= 0; i--) begin
        repeat ((pat[i] ? 3 : 1) * U) exp_q.push_back(1'b1);
        repeat ((i > 0 ? 1 : 3) * U) exp_q.push_back(1'b0);
      end
    end
  endfunction

  // Call in an IDLE cycle (after a negedge); accepts on the next posedge.
  task automatic play(input logic [2:0] len, input logic [4:0] pat,
                      input bit chain, input logic [2:0] nlen, input logic [4:0] npat);
    int k;
    sym_len  = len;
    sym_pat  = pat;
    in_valid = 1'b1;
    @(posedge clk); #1;
    if (chain) begin
      sym_len = nlen;
      sym_pat = npat;
    end else begin
      in_valid = 1'b0;
    end
    build(len, pat);
    k = 0;
    foreach (exp_q[i]) begin
      @(negedge clk);
      chk("key", key, exp_q[i]);
      chk("busy", busy, 1);
      chk("done_early", done, 0);
`ifdef MORSE_TONE_EN
      if (exp_q[i]) begin
        chk("tone", tone, (k / TH) % 2);
        k++;
      end else begin
        chk("tone_gap", tone, 0);
        k = 0;
      end
`else
      chk("tone_off", tone, 0);
`endif
    end
    @(negedge clk);
    chk("done", done, 1);
    chk("ready_after", in_ready, 1);
  endtask

  initial begin
    logic [2:0] rl;
    logic [4:0] rp;

    #12;
    chk("rst_key", key, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tone", tone, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_done", done, 0);

    play(3'd2, 5'b00001, 1'b0, 3'd0, 5'd0);
    @(negedge clk);
    chk("done_one_cycle", done, 0);

    play(3'd1, 5'b00000, 1'b1, 3'd1, 5'b00001);
    play(3'd1, 5'b00001, 1'b0, 3'd0, 5'd0);
    play(3'd0, 5'b10101, 1'b0, 3'd0, 5'd0);
    play(3'd7, 5'b11111, 1'b0, 3'd0, 5'd0);

    for (int r = 0; r < 6; r++) begin
      rl = 3'($urandom_range(0, 7));
      rp = 5'($urandom);
      play(rl, rp, 1'b0, 3'd0, 5'd0);
    end

    // Abort during the dash of 'A'.
    sym_len  = 3'd2;
    sym_pat  = 5'b00001;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    abort = 1'b1;
    @(negedge clk);
    chk("abort_pre_key", key, 1);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_key", key, 0);
    chk("abort_ready", in_ready, 1);
    chk("abort_done", done, 0);
    @(negedge clk);
    chk("abort_done_late", done, 0);
    play(3'd1, 5'b00001, 1'b0, 3'd0, 5'd0);

    // Abort in IDLE together with in_valid: the accept wins.
    sym_len  = 3'd1;
    sym_pat  = 5'b00000;
    in_valid = 1'b1;
    abort    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    abort    = 1'b0;
    @(negedge clk);
    chk("idle_abort_key", key, 1);
    chk("idle_abort_ready", in_ready, 0);
    repeat (15) @(negedge clk);
    @(negedge clk);
    chk("idle_abort_done", done, 1);

    // Asynchronous reset in the middle of a mark.
    sym_len  = 3'd2;
    sym_pat  = 5'b00001;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    chk("pre_reset_key", key, 1);
    reset_n = 1'b0;
    #1;
    chk("async_key", key, 0);
    chk("async_ready", in_ready, 1);
    chk("async_busy", busy, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_reset_done", done, 0);
      chk("post_reset_key", key, 0);
      chk("post_reset_ready", in_ready, 1);
    end
    play(3'd1, 5'b00000, 1'b0, 3'd0, 5'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
